cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  MIPS CP0 register file and exception/interrupt state holder. Serves WB-stage MTC0/MFC0 accesses,
//  commits exceptions and ERET, and runs the Count/Compare timer. Drives the interrupt request and EPC
//  used for pipeline flush and redirect.
//  Caller gates cp0_wen, ws_ex and ws_eret with stage-valid.
// PARAMETERS
//  COUNT_DIV  2  Count increments once every COUNT_DIV clocks (>=1)
//  BEV_RESET  1  reset value of Status.BEV (bit 22, read-only)
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  cp0_addr     in   8   {rd[4:0],sel[2:0]}; used for both MTC0 and MFC0
//  cp0_wen      in   1   MTC0 write strobe
//  cp0_wdata    in   32  MTC0 data
//  cp0_rdata    out  32  MFC0 data, combinational from cp0_addr
//  ws_ex        in   1   exception commit this cycle
//  ws_excode    in   5   ExcCode of committing exception
//  ws_bd        in   1   faulting instruction is in a delay slot
//  ws_pc        in   32  PC of faulting instruction
//  ws_badvaddr  in   32  faulting address (AdEL=4/AdES=5 only)
//  ws_eret      in   1   ERET commit this cycle
//  ext_int      in   6   hardware interrupt lines HW5..HW0 (level)
//  cp0_epc      out  32  current EPC (ERET target)
//  cp0_status   out  32  current Status
//  cp0_cause    out  32  current Cause
//  int_pending  out  1   interrupt request to pipeline
// BEHAVIOUR
//  Address map:
//   BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0}, EPC {14,0}.
//   Unmapped addresses read 0; writes to them are ignored.
//  Reset values: all registers 0 except Status=BEV_RESET<<22. Internal tick counter=0.
//   Outputs therefore reset to cp0_epc=0, cp0_cause=0, int_pending=0.
//  Writable fields:
//   Status: IM[15:8], EXL[1], IE[0]; all other bits read 0 (BEV fixed).
//   Cause: IP[9:8] only. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-only.
//   Count, Compare, EPC: full 32 bits. BadVAddr: read-only.
//  Writes take effect at the next clock edge; a same-cycle MFC0 returns the old value.
//  Priority per cycle: ws_ex > ws_eret > cp0_wen. A lower-priority event in the same cycle is dropped.
//  Exception (ws_ex=1):
//   - Always: Status.EXL<=1, Cause.ExcCode<=ws_excode.
//   - Only if EXL was 0: EPC<=ws_bd?ws_pc-4:ws_pc and Cause.BD<=ws_bd; otherwise both are kept.
//   - ExcCode 4 or 5: BadVAddr<=ws_badvaddr.
//  ERET (ws_eret=1): Status.EXL<=0; no other state changes.
//  Timer:
//   - Tick counter counts 0..COUNT_DIV-1 and wraps; Count<=Count+1 (mod 2^32) on wrap.
//   - Writing Count loads cp0_wdata and zeroes the tick counter.
//   - TI<=1 on the edge where Count increments to a value equal to Compare.
//   - Writing Compare clears TI; this wins over a same-cycle set.
//   - TI stays set until cleared; Count wrap 0xFFFFFFFF->0 behaves normally.
//  Cause.IP[15:10] is registered each cycle from {ext_int[5]|TI, ext_int[4:0]} (one-cycle latency).
//  int_pending = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP). Combinational from registers.
//  Reset asserted mid-operation restores all reset values immediately, including the timer.
// TESTING
//  1. Reset, then MTC0 Status=0xFFFFFFFF -> MFC0 Status reads 0x0040FF03; Cause reads 0.
//  2. ws_ex, excode=4, pc=0xBFC00100, bd=1, badvaddr=0x1234 ->
//     EPC=0xBFC000FC, Cause=0x80000010, BadVAddr=0x1234, EXL=1.
//     A second ws_ex with pc=0x200 leaves EPC unchanged.
//  3. ws_eret together with cp0_wen to EPC -> EXL=0 and EPC unchanged.
//     ws_ex together with ws_eret -> EXL=1.
//  4. COUNT_DIV=2, Compare=5, Count=0 -> TI=1 after 10 clocks, Cause.IP7=1 the next cycle.
//     With Status=0x00008001, int_pending=1. MTC0 Compare clears TI; int_pending drops after IP7.
//  5. Status=0x00000401, ext_int=6'b000001 -> int_pending=1 two cycles later.
//     Setting EXL=1 forces int_pending=0.
//     MTC0 Cause=0x300 with IM[1:0]=11 -> IP[9:8]=11, int_pending=1.
//  6. Assert reset mid-count with TI=1 -> all outputs 0 except Status=0x00400000.
//     Count restarts from 0.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: MTC0/MFC0 access, exception/ERET commit, Count/Compare timer
// and interrupt request generation for the pipeline.
module cp0_regfile #(
  parameter int unsigned COUNT_DIV = 2,
  parameter bit          BEV_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cp0_addr,
  input  logic        cp0_wen,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_eret,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        int_pending
);

  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};
  localparam int unsigned TW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]   badvaddr, count, compare, epc;
  logic [7:0]    im;
  logic          exl, ie;
  logic          bd, ti;
  logic [5:0]    ip_hw;
  logic [1:0]    ip_sw;
  logic [4:0]    excode;
  logic [TW-1:0] tick;

  logic        wr_en, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        tick_wrap;
  logic [31:0] count_inc;

  // MTC0 is dropped whenever an exception or ERET commits in the same cycle.
  assign wr_en      = cp0_wen & ~ws_ex & ~ws_eret;
  assign wr_count   = wr_en & (cp0_addr == ADDR_COUNT);
  assign wr_compare = wr_en & (cp0_addr == ADDR_COMPARE);
  assign wr_status  = wr_en & (cp0_addr == ADDR_STATUS);
  assign wr_cause   = wr_en & (cp0_addr == ADDR_CAUSE);
  assign wr_epc     = wr_en & (cp0_addr == ADDR_EPC);

  assign tick_wrap = (tick == TW'(COUNT_DIV - 1));
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      excode   <= '0;
      tick     <= '0;
    end else begin
      if (wr_count) begin
        count <= cp0_wdata;
        tick  <= '0;
      end else if (tick_wrap) begin
        count <= count_inc;
        tick  <= '0;
      end else begin
        tick  <= tick + TW'(1);
      end

      // Compare write clears TI and overrides a match in the same cycle.
      if (wr_compare)
        ti <= 1'b0;
      else if (!wr_count && tick_wrap && (count_inc == compare))
        ti <= 1'b1;

      if (wr_compare)
        compare <= cp0_wdata;

      ip_hw <= {ext_int[5] | ti, ext_int[4:0]};

      if (ws_ex) begin
        exl    <= 1'b1;
        excode <= ws_excode;
        if (!exl) begin
          epc <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
          bd  <= ws_bd;
        end
        if ((ws_excode == 5'd4) || (ws_excode == 5'd5))
          badvaddr <= ws_badvaddr;
      end else if (ws_eret) begin
        exl <= 1'b0;
      end else begin
        if (wr_status) begin
          im  <= cp0_wdata[15:8];
          exl <= cp0_wdata[1];
          ie  <= cp0_wdata[0];
        end
        if (wr_cause)
          ip_sw <= cp0_wdata[9:8];
        if (wr_epc)
          epc <= cp0_wdata;
      end
    end
  end

  assign cp0_status  = {9'b0, BEV_RESET, 6'b0, im, 6'b0, exl, ie};
  assign cp0_cause   = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, excode, 2'b0};
  assign cp0_epc     = epc;
  assign int_pending = ie & ~exl & (|(im & {ip_hw, ip_sw}));

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = cp0_status;
      ADDR_CAUSE:    cp0_rdata = cp0_cause;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: register access, exception/ERET, timer and interrupts.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cp0_addr;
  logic        cp0_wen;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        ws_ex;
  logic [4:0]  ws_excode;
  logic        ws_bd;
  logic [31:0] ws_pc;
  logic [31:0] ws_badvaddr;
  logic        ws_eret;
  logic [5:0]  ext_int;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic        int_pending;

  int unsigned checks = 0;
  int unsigned failures = 0;

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STAT = 8'h60;
  localparam logic [7:0] A_CAUS = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;

  cp0_regfile #(.COUNT_DIV(2), .BEV_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .cp0_addr(cp0_addr), .cp0_wen(cp0_wen),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .ws_ex(ws_ex), .ws_excode(ws_excode),
    .ws_bd(ws_bd), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr), .ws_eret(ws_eret),
    .ext_int(ext_int), .cp0_epc(cp0_epc), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cp0_addr = a; cp0_wdata = d; cp0_wen = 1'b1;
    step();
    cp0_wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0;
    ws_ex = 1'b0; ws_excode = '0; ws_bd = 1'b0; ws_pc = '0; ws_badvaddr = '0;
    ws_eret = 1'b0; ext_int = '0;
    step(); step();

    chk("rst_status", cp0_status, 32'h0040_0000);
    chk("rst_cause", cp0_cause, 32'h0);
    chk("rst_epc", cp0_epc, 32'h0);
    chk("rst_intp", {31'b0, int_pending}, 32'h0);
    rd("rst_count", A_CNT, 32'h0);
    reset = 1'b0;

    // 1: Status write mask, same-cycle read returns old value, unmapped address
    cp0_addr = A_STAT; cp0_wdata = 32'hFFFF_FFFF; cp0_wen = 1'b1;
    #1;
    chk("status_old_same_cycle", cp0_rdata, 32'h0040_0000);
    step();
    cp0_wen = 1'b0;
    rd("status_mask", A_STAT, 32'h0040_FF03);
    rd("cause_zero", A_CAUS, 32'h0);
    chk("intp_exl_masks", {31'b0, int_pending}, 32'h0);
    wr(8'h08, 32'hDEAD_BEEF);
    rd("unmapped_read", 8'h08, 32'h0);

    // 2: exception in delay slot, then nested exception
    wr(A_STAT, 32'h0);
    ws_ex = 1'b1; ws_excode = 5'd4; ws_pc = 32'hBFC0_0100; ws_bd = 1'b1; ws_badvaddr = 32'h1234;
    step();
    ws_ex = 1'b0;
    chk("ex_epc_bd", cp0_epc, 32'hBFC0_00FC);
    chk("ex_cause", cp0_cause, 32'h8000_0010);
    rd("ex_badvaddr", A_BADV, 32'h0000_1234);
    chk("ex_status_exl", cp0_status, 32'h0040_0002);
    ws_ex = 1'b1; ws_excode = 5'd8; ws_pc = 32'h200; ws_bd = 1'b0; ws_badvaddr = 32'h5678;
    step();
    ws_ex = 1'b0;
    chk("nested_epc_kept", cp0_epc, 32'hBFC0_00FC);
    chk("nested_cause", cp0_cause, 32'h8000_0020);
    rd("nested_badv_kept", A_BADV, 32'h0000_1234);

    // 3: priority ws_ex > ws_eret > cp0_wen
    ws_eret = 1'b1; cp0_addr = A_EPC; cp0_wdata = 32'h1111_1111; cp0_wen = 1'b1;
    step();
    ws_eret = 1'b0; cp0_wen = 1'b0;
    chk("eret_exl_clr", cp0_status, 32'h0040_0000);
    chk("eret_drops_wen", cp0_epc, 32'hBFC0_00FC);
    ws_ex = 1'b1; ws_eret = 1'b1; ws_excode = 5'd0; ws_pc = 32'h300; ws_bd = 1'b0;
    step();
    ws_ex = 1'b0; ws_eret = 1'b0;
    chk("ex_over_eret", cp0_status, 32'h0040_0002);
    chk("ex_over_eret_epc", cp0_epc, 32'h0000_0300);
    chk("ex_over_eret_cause", cp0_cause, 32'h0);
    ws_eret = 1'b1;
    step();
    ws_eret = 1'b0;
    wr(A_EPC, 32'hA5A5_A5A5);
    rd("epc_write", A_EPC, 32'hA5A5_A5A5);

    // 4: timer with COUNT_DIV=2
    wr(A_STAT, 32'h0000_8001);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    rd("count_loaded", A_CNT, 32'd0);
    for (int i = 0; i < 9; i++) step();
    rd("count_after9", A_CNT, 32'd4);
    chk("ti_not_yet", cp0_cause, 32'h0);
    step();
    chk("ti_set", cp0_cause, 32'h4000_0000);
    chk("intp_before_ip7", {31'b0, int_pending}, 32'h0);
    step();
    chk("ip7_set", cp0_cause, 32'h4000_8000);
    chk("intp_timer", {31'b0, int_pending}, 32'h1);
    wr(A_CMP, 32'h1000);
    chk("ti_cleared", cp0_cause, 32'h0000_8000);
    chk("intp_ip7_lag", {31'b0, int_pending}, 32'h1);
    step();
    chk("intp_drop", {31'b0, int_pending}, 32'h0);

    // 5: hardware and software interrupts
    wr(A_STAT, 32'h0000_0401);
    chk("intp_no_ext", {31'b0, int_pending}, 32'h0);
    ext_int = 6'b000001;
    step(); step();
    chk("intp_ext", {31'b0, int_pending}, 32'h1);
    chk("cause_ip2", cp0_cause, 32'h0000_0400);
    wr(A_STAT, 32'h0000_0403);
    chk("intp_exl_forces0", {31'b0, int_pending}, 32'h0);
    ext_int = 6'b000000;
    wr(A_CAUS, 32'hFFFF_FFFF);
    rd("cause_sw_only", A_CAUS, 32'h0000_0300);
    wr(A_STAT, 32'h0000_0301);
    rd("status_im01", A_STAT, 32'h0040_0301);
    chk("intp_sw", {31'b0, int_pending}, 32'h1);

    // 6: Count wrap sets TI, then asynchronous reset mid-count
    wr(A_CMP, 32'h0);
    wr(A_CNT, 32'hFFFF_FFFF);
    step(); step();
    rd("count_wrapped", A_CNT, 32'h0);
    chk("ti_on_wrap", {31'b0, cp0_cause[30]}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_status", cp0_status, 32'h0040_0000);
    chk("midrst_cause", cp0_cause, 32'h0);
    chk("midrst_epc", cp0_epc, 32'h0);
    chk("midrst_intp", {31'b0, int_pending}, 32'h0);
    step();
    reset = 1'b0;
    step();
    rd("count_restart0", A_CNT, 32'd0);
    step();
    rd("count_restart1", A_CNT, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
